// File: rtl/router_dst_rx_if.sv
// Router output-port handshake as seen by router_dst_rx: FIFO valid/data from the router,
// pop request back to it. The router drives master, the receiver uses slave.
interface router_dst_rx_if;
  logic       vld_out;
  logic [7:0] data_out;
  logic       read_enb;

  modport master (output vld_out, output data_out, input read_enb);
  modport slave  (input vld_out, input data_out, output read_enb);
endinterface

// File: rtl/router_dst_rx.sv
// Destination-side receiver: pops one router output FIFO, reassembles header/payload/parity
// packets, streams bytes downstream and reports status. Define RX_STATS_EN for packet counters.
module router_dst_rx #(
  parameter int unsigned STALL_LIMIT = 25,
  parameter int unsigned GAP_LIMIT   = 64
) (
  input  logic           clock,
  input  logic           resetn,
  router_dst_rx_if.slave rtr,
  input  logic           sink_ready,
  output logic [7:0]     byte_out,
  output logic           byte_vld,
  output logic [1:0]     pkt_addr,
  output logic [5:0]     pkt_len,
  output logic           pkt_done,
  output logic           pkt_err,
  output logic           pkt_abort,
  output logic           stall_warn
`ifdef RX_STATS_EN
  ,
  output logic [15:0]    pkt_cnt,
  output logic [15:0]    err_cnt,
  output logic [15:0]    abort_cnt
`endif
);

  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int GW = $clog2(GAP_LIMIT);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_PARITY, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          rd_pend_q;
  logic [6:0]    rd_left_q, rd_left_d;
  logic [5:0]    remaining_q, remaining_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          byte_vld_q, byte_vld_d;
  logic [1:0]    addr_q, addr_d;
  logic [5:0]    len_q, len_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          abort_q, abort_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic [7:0] rx_data;
  logic       gap_tick, abort_cond, want_rd, rd_issue;

  assign rx_data = rtr.data_out;

  // A header read is always captured the next cycle, so only PAYLOAD/PARITY can starve.
  assign gap_tick   = ((state_q == S_PAYLOAD) || (state_q == S_PARITY)) && !rtr.vld_out && !rd_pend_q;
  assign abort_cond = gap_tick && (gap_cnt_q == GAP_LAST);
  assign want_rd    = (state_q == S_IDLE) ? !rd_pend_q : (rd_left_q != 7'd0);
  assign rd_issue   = rtr.vld_out && sink_ready && (state_q != S_DONE) && !abort_cond
                      && want_rd && resetn;
  assign rtr.read_enb = rd_issue;

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rd_left_d   = rd_left_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    byte_out_d  = byte_out_q;
    byte_vld_d  = 1'b0;
    addr_d      = addr_q;
    len_d       = len_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    abort_d     = 1'b0;

    if (rd_issue && (state_q != S_IDLE)) rd_left_d = rd_left_q - 7'd1;

    unique case (state_q)
      S_IDLE: if (rd_pend_q) begin
        addr_d      = rx_data[1:0];
        len_d       = rx_data[7:2];
        acc_d       = rx_data;
        remaining_d = rx_data[7:2];
        rd_left_d   = {1'b0, rx_data[7:2]} + 7'd1;  // payload plus parity reads
        byte_out_d  = rx_data;
        byte_vld_d  = 1'b1;
        state_d     = (rx_data[7:2] != 6'd0) ? S_PAYLOAD : S_PARITY;
      end
      S_PAYLOAD: if (rd_pend_q) begin
        byte_out_d  = rx_data;
        byte_vld_d  = 1'b1;
        acc_d       = acc_q ^ rx_data;
        remaining_d = remaining_q - 6'd1;
        if (remaining_q == 6'd1) state_d = S_PARITY;
      end
      S_PARITY: if (rd_pend_q) begin
        done_d  = 1'b1;
        err_d   = (rx_data != acc_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        acc_d   = 8'h00;
        state_d = S_IDLE;
      end
    endcase

    if (abort_cond) begin
      state_d     = S_IDLE;
      done_d      = 1'b1;
      err_d       = 1'b1;
      abort_d     = 1'b1;
      acc_d       = 8'h00;
      remaining_d = 6'd0;
      rd_left_d   = 7'd0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rd_issue || !rtr.vld_out) stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + SW'(1);

    gap_cnt_d = '0;
    if (gap_tick && !abort_cond) gap_cnt_d = gap_cnt_q + GW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rd_pend_q   <= 1'b0;
      rd_left_q   <= 7'd0;
      remaining_q <= 6'd0;
      acc_q       <= 8'h00;
      byte_out_q  <= 8'h00;
      byte_vld_q  <= 1'b0;
      addr_q      <= 2'd0;
      len_q       <= 6'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      stall_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_issue;
      rd_left_q   <= rd_left_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      byte_out_q  <= byte_out_d;
      byte_vld_q  <= byte_vld_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      done_q      <= done_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      stall_cnt_q <= stall_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_vld   = byte_vld_q;
  assign pkt_addr   = addr_q;
  assign pkt_len    = len_q;
  assign pkt_done   = done_q;
  assign pkt_err    = err_q;
  assign pkt_abort  = abort_q;
  assign stall_warn = (stall_cnt_q == STALL_MAX);

`ifdef RX_STATS_EN
  logic [15:0] pkt_cnt_q, err_cnt_q, abort_cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_q   <= 16'd0;
      err_cnt_q   <= 16'd0;
      abort_cnt_q <= 16'd0;
    end else begin
      if (done_d && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (done_d && err_d && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      if (done_d && abort_d && (abort_cnt_q != 16'hFFFF)) abort_cnt_q <= abort_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_router_dst_rx.sv
// Directed bench for router_dst_rx: a small router FIFO model feeds packets, a negedge monitor
// collects bytes and status pulses, and check() compares them with hand-computed values.
`timescale 1ns/1ps
module tb_router_dst_rx;
  localparam int STALL_LIMIT = 25;
  localparam int GAP_LIMIT   = 64;

  typedef logic [7:0] bq_t[$];

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       sink_ready = 1'b0;
  logic [7:0] byte_out;
  logic       byte_vld, pkt_done, pkt_err, pkt_abort, stall_warn;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
`ifdef RX_STATS_EN
  logic [15:0] pkt_cnt, err_cnt, abort_cnt;
`endif

  router_dst_rx_if rif();

  router_dst_rx #(.STALL_LIMIT(STALL_LIMIT), .GAP_LIMIT(GAP_LIMIT)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .rtr        (rif),
    .sink_ready (sink_ready),
    .byte_out   (byte_out),
    .byte_vld   (byte_vld),
    .pkt_addr   (pkt_addr),
    .pkt_len    (pkt_len),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .pkt_abort  (pkt_abort),
    .stall_warn (stall_warn)
`ifdef RX_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt),
    .abort_cnt  (abort_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Router FIFO model: a read granted at a posedge presents its byte mid-way through the next cycle.
  logic [7:0] fifo[$];
  logic       rd_q;
  int         underflow = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) rd_q <= 1'b0;
    else         rd_q <= rif.read_enb;
  end

  always @(negedge clock) begin
    if (rd_q) begin
      if (fifo.size() == 0) underflow++;
      else rif.data_out = fifo.pop_front();
    end
    rif.vld_out = (fifo.size() != 0);
  end

  // Monitor
  int         cyc = 0;
  logic [7:0] got[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         last_byte_cyc = 0;
  logic       last_err = 1'b0;
  logic       last_abort = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (byte_vld) begin
      got.push_back(byte_out);
      last_byte_cyc = cyc;
    end
    if (pkt_done) begin
      done_cnt++;
      done_cyc   = cyc;
      last_err   = pkt_err;
      last_abort = pkt_abort;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send(input bq_t pkt);
    foreach (pkt[i]) fifo.push_back(pkt[i]);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < max_cyc) begin
      @(negedge clock); #1;
      n++;
    end
    check({tag, "_done"}, 32'(done_cnt - start), 32'd1);
  endtask

  // Compares the streamed bytes with every byte of pkt except the trailing parity byte.
  task automatic check_pkt(input string tag, input bq_t pkt, input logic [1:0] addr,
                           input logic [5:0] len, input logic err);
    int nb = pkt.size() - 1;
    check({tag, "_nbytes"}, 32'(got.size()), 32'(nb));
    for (int i = 0; i < nb && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(pkt[i]));
    check({tag, "_addr"}, 32'(pkt_addr), 32'(addr));
    check({tag, "_len"}, 32'(pkt_len), 32'(len));
    check({tag, "_err"}, 32'(last_err), 32'(err));
    check({tag, "_abort"}, 32'(last_abort), 32'd0);
    got.delete();
    repeat (3) @(negedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t good, zero, bad, one, abrt;
    int  n;
    logic re_seen;

    good = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    zero = {8'h02, 8'h02};
    bad  = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
    one  = {8'h06, 8'hA5, 8'hA3};
    abrt = {8'h15, 8'h5A, 8'hC3};

    repeat (3) @(negedge clock);
    #1;
    check("rst_byte_vld", 32'(byte_vld), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_pkt_err", 32'(pkt_err), 32'd0);
    check("rst_pkt_abort", 32'(pkt_abort), 32'd0);
    check("rst_pkt_addr", 32'(pkt_addr), 32'd0);
    check("rst_pkt_len", 32'(pkt_len), 32'd0);
    check("rst_stall_warn", 32'(stall_warn), 32'd0);
    check("rst_read_enb", 32'(rif.read_enb), 32'd0);
    resetn = 1'b1;
    sink_ready = 1'b1;

    send(good);
    wait_done("good", 60);
    check_pkt("good", good, 2'd1, 6'd3, 1'b0);

    send(zero);
    wait_done("zero", 60);
    check_pkt("zero", zero, 2'd2, 6'd0, 1'b0);

    send(bad);
    wait_done("bad", 60);
    check_pkt("bad", bad, 2'd1, 6'd3, 1'b1);

    send(one);
    wait_done("after_bad", 60);
    check_pkt("after_bad", one, 2'd2, 6'd1, 1'b0);

    // Backpressure: the FIFO holds a whole packet but the sink refuses for 30 cycles.
    sink_ready = 1'b0;
    send(good);
    @(negedge clock); #1;
    re_seen = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock); #1;
      if (rif.read_enb) re_seen = 1'b1;
      if (c == STALL_LIMIT - 1) check("bp_warn_before", 32'(stall_warn), 32'd0);
      if (c == STALL_LIMIT)     check("bp_warn_rise", 32'(stall_warn), 32'd1);
    end
    check("bp_read_enb_low", 32'(re_seen), 32'd0);
    check("bp_warn_held", 32'(stall_warn), 32'd1);
    sink_ready = 1'b1;
    #1;
    check("bp_read_resume", 32'(rif.read_enb), 32'd1);
    @(negedge clock); #1;
    check("bp_warn_clear", 32'(stall_warn), 32'd0);
    wait_done("bp", 60);
    check_pkt("bp", good, 2'd1, 6'd3, 1'b0);

    // Abort: header promises 5 payload bytes, only 2 arrive.
    send(abrt);
    n = 0;
    while (got.size() < 3 && n < 40) begin
      @(negedge clock); #1;
      n++;
    end
    check("abort_nbytes", 32'(got.size()), 32'd3);
    wait_done("abort", 120);
    check("abort_gap_cycles", 32'(done_cyc - last_byte_cyc), 32'(GAP_LIMIT));
    check("abort_err", 32'(last_err), 32'd1);
    check("abort_flag", 32'(last_abort), 32'd1);
    check("abort_len_held", 32'(pkt_len), 32'd5);
    check("abort_addr_held", 32'(pkt_addr), 32'd1);
    got.delete();
    repeat (2) @(negedge clock);
    #1;
    send(good);
    wait_done("after_abort", 60);
    check_pkt("after_abort", good, 2'd1, 6'd3, 1'b0);

`ifdef RX_STATS_EN
    check("stats_pkt", 32'(pkt_cnt), 32'd7);
    check("stats_err", 32'(err_cnt), 32'd2);
    check("stats_abort", 32'(abort_cnt), 32'd1);
`endif

    // Reset in the middle of a payload.
    send(good);
    n = 0;
    while (got.size() < 2 && n < 40) begin
      @(negedge clock); #1;
      n++;
    end
    check("mrst_started", 32'(got.size()), 32'd2);
    resetn = 1'b0;
    fifo.delete();
    #1;
    check("mrst_byte_vld", 32'(byte_vld), 32'd0);
    check("mrst_byte_out", 32'(byte_out), 32'd0);
    check("mrst_pkt_addr", 32'(pkt_addr), 32'd0);
    check("mrst_pkt_len", 32'(pkt_len), 32'd0);
    check("mrst_pkt_done", 32'(pkt_done), 32'd0);
    check("mrst_read_enb", 32'(rif.read_enb), 32'd0);
`ifdef RX_STATS_EN
    check("mrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("mrst_err_cnt", 32'(err_cnt), 32'd0);
    check("mrst_abort_cnt", 32'(abort_cnt), 32'd0);
`endif
    @(negedge clock); #1;
    resetn = 1'b1;
    got.delete();
    send(good);
    wait_done("post_rst", 60);
    check_pkt("post_rst", good, 2'd1, 6'd3, 1'b0);

    check("fifo_underflow", 32'(underflow), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
